ram_loader: RTL and testbench

Program loader that sits directly upstream of the SAP-1 16×8 RAM. It owns the RAM's address, data and write-enable inputs. On command it accepts a stream of bytes over a valid/ready handshake and writes them to addresses 0 through 2**ADDR_WIDTH−1, keeping a running checksum. At all other times it passes the CPU's address, data and rw straight through to the RAM.

---
 rtl/ram_loader.sv | 113 +++++++++++
 tb/tb_ram_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Program loader for the SAP-1 16x8 RAM: streams bytes into addresses 0..2**ADDR_WIDTH-1
// over valid/ready, keeps a running checksum, and otherwise passes the CPU bus through.
module ram_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  cpu_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rw,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   count;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_en;
  logic                    accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          wr_en <= 1'b0;
          if (start) begin
            state    <= LOAD;
            count    <= '0;
            checksum <= '0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            wr_addr  <= count;
            wr_data  <= in_data;
            wr_en    <= 1'b1;
            count    <= count + ADDR_WIDTH'(1);
            checksum <= checksum + in_data;
            // Final location accepted: stop taking bytes, let the last write land.
            if (count == LAST_ADDR) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end else begin
            wr_en <= 1'b0;
          end
        end

        FLUSH: begin
          state <= DONE;
          wr_en <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          wr_en    <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // busy is a register that is high exactly in LOAD/FLUSH, so the mux select never glitches.
  always_comb begin
    ram_addr = cpu_addr;
    ram_data = cpu_data;
    ram_rw   = cpu_rw;
    if (busy) begin
      ram_addr = wr_addr;
      ram_data = wr_data;
      ram_rw   = wr_en;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed testbench for ram_loader with a negedge-sampling 16x8 RAM model downstream.
module tb_ram_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_rw   = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_rw;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram_mem [DEPTH];
  int            wr_count = 0;

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_rw   (cpu_rw),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_rw   (ram_rw),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // SAP-1 RAM: commits on the falling edge.
  always @(negedge clk) begin
    if (ram_rw === 1'b1) begin
      ram_mem[ram_addr] = ram_data;
      wr_count++;
    end
  end

  function automatic logic [DW-1:0] byte_for(input int mode, input int i);
    logic [DW-1:0] b;
    case (mode)
      0:       b = 8'(i);
      1:       b = 8'hFF;
      2:       b = 8'(i * 17);
      default: b = 8'(8'h11 + i);
    endcase
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then streams bytes until done rises, stop_after bytes are taken, or timeout.
  task automatic load_stream(input int mode, input bit toggle, input int stop_after,
                             input bit hostile_cpu, output int done_cycle, output bit owned);
    int idx = 0;
    int cyc = 0;
    bit acc;
    done_cycle = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    owned = (in_ready === 1'b1) && (busy === 1'b1);
    if (hostile_cpu) begin
      cpu_addr = 4'd5;
      cpu_data = 8'h00;
      cpu_rw   = 1'b1;
    end
    while (cyc < 80) begin
      in_valid = (idx < stop_after) && (!toggle || (cyc % 2 == 0));
      in_data  = byte_for(mode, (idx < DEPTH) ? idx : 0);
      acc = in_valid && (in_ready === 1'b1);
      tick;
      cyc++;
      if (acc) idx++;
      if (done === 1'b1) begin
        done_cycle = cyc;
        break;
      end
      if (stop_after < DEPTH && idx == stop_after) break;
    end
    in_valid = 1'b0;
    cpu_rw   = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++;
    if (checksum !== 8'h00) begin errors++; $display("[TB] FAIL reset_checksum got %h want 00", checksum); end
    cpu_addr = 4'd5;
    cpu_data = 8'hAA;
    cpu_rw   = 1'b1;
    #1;
    checks++;
    if (ram_addr !== 4'd5 || ram_data !== 8'hAA || ram_rw !== 1'b1) begin
      errors++;
      $display("[TB] FAIL passthrough got %h/%h/%b want 5/aa/1", ram_addr, ram_data, ram_rw);
    end
    tick;
    cpu_rw = 1'b0;
    checks++;
    if (ram_mem[5] !== 8'hAA) begin errors++; $display("[TB] FAIL cpu_write got %h want aa", ram_mem[5]); end
  endtask

  task automatic test_continuous;
    int dc;
    bit own;
    wr_count = 0;
    load_stream(0, 1'b0, DEPTH, 1'b0, dc, own);
    checks++;
    if (own !== 1'b1) begin errors++; $display("[TB] FAIL cont_owned_after_start got %b want 1", own); end
    // done rises 17 edges after the start edge: 16 accepts plus FLUSH.
    checks++;
    if (dc != 17) begin errors++; $display("[TB] FAIL cont_done_cycle got %0d want 17", dc); end
    checks++;
    if (checksum !== 8'h78) begin errors++; $display("[TB] FAIL cont_checksum got %h want 78", checksum); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy_after got %b want 0", busy); end
    tick;
    checks++;
    if (wr_count != 16) begin errors++; $display("[TB] FAIL cont_writes got %0d want 16", wr_count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_mem[i] !== 8'(i)) begin errors++; $display("[TB] FAIL cont_ram[%0d] got %h want %h", i, ram_mem[i], 8'(i)); end
    end
  endtask

  task automatic test_wrap;
    int dc;
    bit own;
    load_stream(1, 1'b0, DEPTH, 1'b1, dc, own);
    checks++;
    if (dc != 17) begin errors++; $display("[TB] FAIL wrap_done_cycle got %0d want 17", dc); end
    checks++;
    if (checksum !== 8'hF0) begin errors++; $display("[TB] FAIL wrap_checksum got %h want f0", checksum); end
    tick;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_mem[i] !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_ram[%0d] got %h want ff", i, ram_mem[i]); end
    end
  endtask

  task automatic test_toggle;
    int dc;
    bit own;
    wr_count = 0;
    load_stream(0, 1'b1, DEPTH, 1'b0, dc, own);
    checks++;
    if (dc != 32) begin errors++; $display("[TB] FAIL toggle_done_cycle got %0d want 32", dc); end
    checks++;
    if (checksum !== 8'h78) begin errors++; $display("[TB] FAIL toggle_checksum got %h want 78", checksum); end
    tick;
    checks++;
    if (wr_count != 16) begin errors++; $display("[TB] FAIL toggle_writes got %0d want 16", wr_count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_mem[i] !== 8'(i)) begin errors++; $display("[TB] FAIL toggle_ram[%0d] got %h want %h", i, ram_mem[i], 8'(i)); end
    end
  endtask

  task automatic test_reset_mid_load;
    int dc;
    bit own;
    load_stream(3, 1'b0, 6, 1'b0, dc, own);
    checks++;
    if (checksum !== 8'h75 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_checksum got %h busy %b want 75 busy 1", checksum, busy);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rst_flags got busy %b ready %b done %b want 0 0 0", busy, in_ready, done);
    end
    checks++;
    if (checksum !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_checksum got %h want 00", checksum); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ram_mem[i] !== 8'(8'h11 + i)) begin
        errors++;
        $display("[TB] FAIL mid_ram[%0d] got %h want %h", i, ram_mem[i], 8'(8'h11 + i));
      end
    end
    checks++;
    if (ram_mem[6] !== 8'h06) begin errors++; $display("[TB] FAIL mid_ram6_untouched got %h want 06", ram_mem[6]); end
    load_stream(2, 1'b0, DEPTH, 1'b0, dc, own);
    checks++;
    if (dc != 17 || checksum !== 8'hF8) begin
      errors++;
      $display("[TB] FAIL reload got cycle %0d checksum %h want 17 f8", dc, checksum);
    end
    tick;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_mem[i] !== 8'(i * 17)) begin
        errors++;
        $display("[TB] FAIL reload_ram[%0d] got %h want %h", i, ram_mem[i], 8'(i * 17));
      end
    end
  endtask

  task automatic test_ignore;
    int dc;
    bit own;
    wr_count = 0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_valid_ready got ready %b busy %b want 0 0", in_ready, busy);
    end
    checks++;
    if (checksum !== 8'hF8 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_valid_state got checksum %h done %b want f8 1", checksum, done);
    end
    checks++;
    if (wr_count != 0) begin errors++; $display("[TB] FAIL idle_valid_writes got %0d want 0", wr_count); end
    load_stream(3, 1'b0, 3, 1'b0, dc, own);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_in_load got busy %b ready %b done %b want 1 1 0", busy, in_ready, done);
    end
    checks++;
    if (checksum !== 8'h36) begin errors++; $display("[TB] FAIL start_in_load_checksum got %h want 36", checksum); end
    for (int i = 3; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 + i);
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL ignore_done_early got %b want 0", done); end
    tick;
    checks++;
    if (done !== 1'b1 || checksum !== 8'h88) begin
      errors++;
      $display("[TB] FAIL ignore_final got done %b checksum %h want 1 88", done, checksum);
    end
    tick;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_mem[i] !== 8'(8'h11 + i)) begin
        errors++;
        $display("[TB] FAIL ignore_ram[%0d] got %h want %h", i, ram_mem[i], 8'(8'h11 + i));
      end
    end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_wrap;
    test_toggle;
    test_reset_mid_load;
    test_ignore;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
